div8_seq_ctrl: RTL and testbench

//  Multi-cycle unsigned 8-bit divider controller for the ALU. Sequences one

---
 rtl/div8_pkg.sv | 10 +
 rtl/div8_seq_ctrl_if.sv | 24 ++
 rtl/div8_step.sv | 19 +
 rtl/div8_seq_ctrl.sv | 95 +++++++++
 tb/tb_div8_seq_ctrl.sv | 127 ++++++++++++
 5 files changed

// File: rtl/div8_pkg.sv
// Shared constants for the sequential 8-bit divider.
// FSM encoding, default width and iteration-counter width.
package div8_pkg;
  localparam int DIV_W = 8;
  localparam int CNT_W = $clog2(DIV_W) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/div8_seq_ctrl_if.sv
// Start/busy/done handshake bundle between control unit and divider.
// master = control unit, slave = divider.
interface div8_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             dz;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, dz
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, dz
  );
endinterface

// File: rtl/div8_step.sv
// One restoring-division iteration: WIDTH+1-bit trial subtract.
// Borrow out selects restore versus accept.
module div8_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_w,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);
  logic [WIDTH+1:0] trial;

  // Extra top bit is the borrow of the WIDTH+1-bit subtract.
  assign trial = {1'b0, rem_w, dvd_msb} - {2'b00, divisor};
  assign q_bit = ~trial[WIDTH+1];
  assign next_rem = q_bit ? trial[WIDTH-1:0]
                          : {rem_w[WIDTH-2:0], dvd_msb};
endmodule

// File: rtl/div8_seq_ctrl.sv
// Multi-cycle unsigned restoring divider controller, one quotient bit per clock.
// Define DIV8_EARLY_EXIT_EN to finish immediately when divisor > dividend.
module div8_seq_ctrl
  import div8_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input logic           clk,
  input logic           rst_n,
  div8_seq_ctrl_if.slave bus
);
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_w;
  logic [WIDTH-1:0] dvd_w;
  logic [WIDTH-1:0] q_w;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] rem_r;
  logic             dz_r;
  logic [WIDTH-1:0] next_rem;
  logic             q_bit;

  div8_step #(.WIDTH(WIDTH)) u_step (
    .rem_w   (rem_w),
    .dvd_msb (dvd_w[WIDTH-1]),
    .divisor (dvs),
    .next_rem(next_rem),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      rem_w <= '0;
      dvd_w <= '0;
      q_w   <= '0;
      dvs   <= '0;
      quo_r <= '0;
      rem_r <= '0;
      dz_r  <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == S_IDLE): begin
          if (bus.start) begin
            dvs   <= bus.divisor;
            rem_w <= '0;
            dvd_w <= bus.dividend;
            q_w   <= '0;
            cnt   <= CNT_W'(WIDTH);
            if (bus.divisor == '0) begin
              quo_r <= '1;
              rem_r <= bus.dividend;
              dz_r  <= 1'b1;
              state <= S_DONE;
            end
`ifdef DIV8_EARLY_EXIT_EN
            else if (bus.divisor > bus.dividend) begin
              quo_r <= '0;
              rem_r <= bus.dividend;
              dz_r  <= 1'b0;
              state <= S_DONE;
            end
`endif
            else begin
              state <= S_CALC;
            end
          end
        end
        (state == S_CALC): begin
          rem_w <= next_rem;
          dvd_w <= {dvd_w[WIDTH-2:0], 1'b0};
          q_w   <= {q_w[WIDTH-2:0], q_bit};
          cnt   <= cnt - CNT_W'(1);
          // Last iteration: publish results straight from the step outputs.
          if (cnt == CNT_W'(1)) begin
            quo_r <= {q_w[WIDTH-2:0], q_bit};
            rem_r <= next_rem;
            dz_r  <= 1'b0;
            state <= S_DONE;
          end
        end
        (state == S_DONE): state <= S_IDLE;
        default:           state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = (state == S_CALC);
  assign bus.done      = (state == S_DONE);
  assign bus.quotient  = quo_r;
  assign bus.remainder = rem_r;
  assign bus.dz        = dz_r;
endmodule

// File: tb/tb_div8_seq_ctrl.sv
// Self-checking bench for div8_seq_ctrl: directed cases plus random operands
// against an arithmetic reference (a / b, a % b).
module tb_div8_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   nchk = 0;
  int   nerr = 0;

`ifdef DIV8_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  div8_seq_ctrl_if #(.WIDTH(8)) bus ();

  div8_seq_ctrl #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one division and check result, latency, busy length and hold.
  task automatic run(input logic [7:0] a, input logic [7:0] b,
                     input string tag);
    logic [7:0] eq, er;
    logic       edz;
    int         elat, lat, bsy;
    if (b == 8'd0) begin
      eq = 8'hFF; er = a; edz = 1'b1; elat = 0;
    end else begin
      eq = a / b; er = a % b; edz = 1'b0;
      elat = (EARLY && (b > a)) ? 0 : 8;
    end
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.dividend = 8'($urandom); bus.divisor = 8'($urandom);
    lat = 0; bsy = 0;
    while (!bus.done && lat < 20) begin
      if (bus.busy) bsy++;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_busycyc"}, bsy, elat);
    chk({tag, "_q"}, bus.quotient, eq);
    chk({tag, "_r"}, bus.remainder, er);
    chk({tag, "_dz"}, bus.dz, edz);
    chk({tag, "_excl"}, bus.busy & bus.done, 0);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {bus.done, bus.busy}, 2'b00);
    chk({tag, "_hold"}, {bus.quotient, bus.remainder}, {eq, er});
  endtask

  initial begin
    int dones, cyc;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    #12;
    chk("reset_out", {bus.busy, bus.done, bus.quotient, bus.remainder, bus.dz},
        '0);
    @(negedge clk); rst_n = 1'b1;

    run(8'd200, 8'd7, "t1_200_7");
    run(8'd255, 8'd1, "t2_255_1");
    run(8'd0, 8'd9, "t2_0_9");
    run(8'd5, 8'd0, "t3_5_0");
    run(8'd9, 8'd3, "t3_9_3");

    // Second start during CALC must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd10;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd5;
    @(posedge clk); #1; bus.start = 1'b0;
    dones = 0;
    for (cyc = 0; cyc < 14; cyc++) begin
      if (bus.done) begin
        dones++;
        chk("t4_q", bus.quotient, 8'd10);
        chk("t4_r", bus.remainder, 8'd0);
      end
      @(posedge clk); #1;
    end
    chk("t4_single_done", dones, 1);
    chk("t4_idle", bus.busy, 1'b0);

    // Asynchronous reset in the middle of a calculation.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd7;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_out", {bus.busy, bus.done, bus.quotient, bus.remainder, bus.dz},
        '0);
    @(negedge clk); rst_n = 1'b1;
    run(8'd17, 8'd4, "t5_17_4");

    run(8'd3, 8'd9, "t6_3_9");

    for (int i = 0; i < 40; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      run(a, b, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
